// File: rtl/p1v_resgen_pkg.sv
// Shared encodings for the P1V board-level reset generator: reset causes and FSM states.
package p1v_resgen_pkg;

  localparam logic [1:0] CAUSE_POR = 2'd0;
  localparam logic [1:0] CAUSE_BTN = 2'd1;
  localparam logic [1:0] CAUSE_SW  = 2'd2;
  localparam logic [1:0] CAUSE_WDT = 2'd3;

  typedef enum logic [1:0] {
    ST_HOLD     = 2'd0,
    ST_RUN      = 2'd1,
    ST_BTN_WAIT = 2'd2
  } state_t;

endpackage

// File: rtl/p1v_debounce.sv
// Pushbutton conditioner: two-flop synchronizer followed by a stability counter.
// The output follows the synchronized level only after it has differed for DEBOUNCE_CYCLES cycles in a row.
module p1v_debounce #(
  parameter int DEBOUNCE_CYCLES = 160_000
)(
  input  logic clk,
  input  logic res,
  input  logic din,
  output logic dout
);

  localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);

  logic          sync1;
  logic          sync2;
  logic [DW-1:0] cnt;

  // Any cycle where the synchronized level agrees with the output restarts the count.
  always_ff @(posedge clk) begin
    if (res) begin
      sync1 <= 1'b1;
      sync2 <= 1'b1;
      cnt   <= '0;
      dout  <= 1'b1;
    end else begin
      sync1 <= din;
      sync2 <= sync1;
      if (sync2 == dout) begin
        cnt <= '0;
      end else if (cnt == DW'(DEBOUNCE_CYCLES - 1)) begin
        dout <= sync2;
        cnt  <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/p1v_resgen.sv
// Board-level reset generator producing the active-low P1V core reset from POR, button, software and watchdog.
// Optional watchdog is built only when P1V_RESGEN_WDT_EN is defined.
module p1v_resgen
  import p1v_resgen_pkg::*;
#(
  parameter int CNT_W           = 24,
  parameter int HOLD_CYCLES     = 16_000_000,
  parameter int DEBOUNCE_CYCLES = 160_000,
  parameter int WDT_CYCLES      = 16_000_000
)(
  input  logic       clk,
  input  logic       res,
  input  logic       btn_n,
  input  logic       sw_res,
  input  logic       wdt_en,
  input  logic       wdt_kick,
  output logic       resn,
  output logic [1:0] cause,
  output logic [7:0] res_count,
  output logic       busy
);

  state_t           state;
  logic [CNT_W-1:0] hold_cnt;
  logic             sw_prev;
  logic             btn_db;
  logic             wdt_expired;
  logic             sw_edge;

  p1v_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_debounce (
    .clk (clk),
    .res (res),
    .din (btn_n),
    .dout(btn_db)
  );

  assign sw_edge = sw_res & ~sw_prev;

`ifdef P1V_RESGEN_WDT_EN
  logic [CNT_W-1:0] wdt_cnt;

  always_ff @(posedge clk) begin
    if (res) begin
      wdt_cnt <= '0;
    end else if (state != ST_RUN || !wdt_en || wdt_kick || wdt_expired) begin
      wdt_cnt <= '0;
    end else begin
      wdt_cnt <= wdt_cnt + 1'b1;
    end
  end

  assign wdt_expired = (wdt_cnt == CNT_W'(WDT_CYCLES - 1));
`else
  logic wdt_unused;
  assign wdt_unused  = wdt_en | wdt_kick | (WDT_CYCLES == 0);
  assign wdt_expired = 1'b0;
`endif

  // sw_prev keeps tracking in every state so a request held across a reset cannot retrigger.
  always_ff @(posedge clk) begin
    if (res) begin
      state     <= ST_HOLD;
      hold_cnt  <= '0;
      resn      <= 1'b0;
      cause     <= CAUSE_POR;
      res_count <= 8'd0;
      busy      <= 1'b1;
      sw_prev   <= 1'b1;
    end else begin
      sw_prev <= sw_res;
      unique case (state)
        ST_HOLD: begin
          if (!btn_db) begin
            state    <= ST_BTN_WAIT;
            hold_cnt <= '0;
            cause    <= CAUSE_BTN;
          end else if (hold_cnt == CNT_W'(HOLD_CYCLES - 1)) begin
            state    <= ST_RUN;
            hold_cnt <= '0;
            resn     <= 1'b1;
            busy     <= 1'b0;
          end else begin
            hold_cnt <= hold_cnt + 1'b1;
          end
        end
        ST_BTN_WAIT: begin
          hold_cnt <= '0;
          if (btn_db) begin
            state <= ST_HOLD;
          end
        end
        ST_RUN: begin
          if (!btn_db || wdt_expired || sw_edge) begin
            hold_cnt <= '0;
            resn     <= 1'b0;
            busy     <= 1'b1;
            if (res_count != 8'hFF) begin
              res_count <= res_count + 8'd1;
            end
            if (!btn_db) begin
              state <= ST_BTN_WAIT;
              cause <= CAUSE_BTN;
            end else if (wdt_expired) begin
              state <= ST_HOLD;
              cause <= CAUSE_WDT;
            end else begin
              state <= ST_HOLD;
              cause <= CAUSE_SW;
            end
          end
        end
        default: begin
          state    <= ST_HOLD;
          hold_cnt <= '0;
          resn     <= 1'b0;
          busy     <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_p1v_resgen.sv
// Self-checking bench for p1v_resgen: directed timing checks plus randomized traffic against a cycle model.
`timescale 1ns/1ps
module tb_p1v_resgen;

  localparam int HOLD = 16;
  localparam int DB   = 4;
  localparam int WDT  = 32;

  logic       clk = 1'b0;
  logic       res, btn_n, sw_res, wdt_en, wdt_kick;
  logic       resn, busy;
  logic [1:0] cause;
  logic [7:0] res_count;

  int checks = 0;
  int errors = 0;
  bit chk_on = 1'b0;
  int exp_cnt;

  always #5 clk = ~clk;

  p1v_resgen #(
    .CNT_W(24),
    .HOLD_CYCLES(HOLD),
    .DEBOUNCE_CYCLES(DB),
    .WDT_CYCLES(WDT)
  ) dut (
    .clk      (clk),
    .res      (res),
    .btn_n    (btn_n),
    .sw_res   (sw_res),
    .wdt_en   (wdt_en),
    .wdt_kick (wdt_kick),
    .resn     (resn),
    .cause    (cause),
    .res_count(res_count),
    .busy     (busy)
  );

  // Reference model: remaining hold edges, a "waiting for release" flag, and a run-length view of the button.
  int m_hold_left;
  bit m_wait;
  int m_cause;
  int m_count;
  bit m_sw_prev;
  int m_wdt_idle;
  bit m_s1, m_s2, m_db;
  int m_stable;

  always @(posedge clk) begin : model
    bit press, running, fire, sw_edge, db_old, s2_old;
    if (res) begin
      m_hold_left = HOLD;
      m_wait      = 1'b0;
      m_cause     = 0;
      m_count     = 0;
      m_sw_prev   = 1'b1;
      m_wdt_idle  = 0;
      m_s1        = 1'b1;
      m_s2        = 1'b1;
      m_db        = 1'b1;
      m_stable    = 0;
    end else begin
      db_old  = m_db;
      s2_old  = m_s2;
      press   = !db_old;
      running = (m_hold_left == 0) && !m_wait;
      fire    = 1'b0;
`ifdef P1V_RESGEN_WDT_EN
      fire    = running && (m_wdt_idle == WDT - 1);
`endif
      sw_edge = sw_res && !m_sw_prev;
      if (m_wait) begin
        if (!press) begin
          m_wait      = 1'b0;
          m_hold_left = HOLD;
        end
      end else if (!running) begin
        if (press) begin
          m_wait      = 1'b1;
          m_hold_left = 0;
          m_cause     = 1;
        end else begin
          m_hold_left = m_hold_left - 1;
        end
      end else if (press || fire || sw_edge) begin
        m_count = (m_count < 255) ? m_count + 1 : 255;
        if (press) begin
          m_wait  = 1'b1;
          m_cause = 1;
        end else begin
          m_hold_left = HOLD;
          m_cause     = fire ? 3 : 2;
        end
      end
      if (!running || !wdt_en || wdt_kick || fire) m_wdt_idle = 0;
      else m_wdt_idle = m_wdt_idle + 1;
      m_sw_prev = sw_res;
      if (s2_old != db_old) begin
        m_stable = m_stable + 1;
        if (m_stable == DB) begin
          m_db     = s2_old;
          m_stable = 0;
        end
      end else begin
        m_stable = 0;
      end
      m_s2 = m_s1;
      m_s1 = btn_n;
    end
  end

  task automatic checkOutput(input string tag, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic applyStimulus(input logic r, input logic b, input logic s, input logic e, input logic k);
    res      = r;
    btn_n    = b;
    sw_res   = s;
    wdt_en   = e;
    wdt_kick = k;
    @(posedge clk);
    #1;
  endtask

  task automatic holdInputs(input int n);
    repeat (n) applyStimulus(res, btn_n, sw_res, wdt_en, wdt_kick);
  endtask

  always @(negedge clk) begin
    if (chk_on) begin
      logic m_resn;
      m_resn = !((m_hold_left > 0) || m_wait);
      checkOutput("mdl_resn", resn, m_resn);
      checkOutput("mdl_busy", busy, !m_resn);
      checkOutput("mdl_cause", cause, m_cause[7:0]);
      checkOutput("mdl_count", res_count, m_count[7:0]);
    end
  end

  initial begin
    logic b;
    int   btn_left;

    applyStimulus(1, 1, 0, 0, 0);
    applyStimulus(1, 1, 0, 0, 0);
    chk_on = 1'b1;
    checkOutput("rst_resn", resn, 0);
    checkOutput("rst_busy", busy, 1);
    checkOutput("rst_cause", cause, 0);
    checkOutput("rst_count", res_count, 0);

    // Power-on: resn rises on the 16th edge after res drops.
    applyStimulus(0, 1, 0, 0, 0);
    holdInputs(14);
    checkOutput("por_resn_e15", resn, 0);
    holdInputs(1);
    checkOutput("por_resn_e16", resn, 1);
    checkOutput("por_busy", busy, 0);
    checkOutput("por_cause", cause, 0);
    checkOutput("por_count", res_count, 0);

    // Button press of 20 cycles, then release.
    applyStimulus(0, 0, 0, 0, 0);
    holdInputs(5);
    checkOutput("btn_resn_e6", resn, 1);
    holdInputs(1);
    checkOutput("btn_resn_e7", resn, 0);
    checkOutput("btn_cause", cause, 1);
    checkOutput("btn_count", res_count, 1);
    checkOutput("btn_busy", busy, 1);
    holdInputs(13);
    applyStimulus(0, 1, 0, 0, 0);
    holdInputs(21);
    checkOutput("btn_rel_e22", resn, 0);
    holdInputs(1);
    checkOutput("btn_rel_e23", resn, 1);
    exp_cnt = 1;

    // Bounce: 3-cycle segments never satisfy the 4-cycle debounce.
    for (int i = 0; i < 30; i++) begin
      applyStimulus(0, ((i / 3) % 2) != 0, 0, 0, 0);
      checkOutput("bounce_resn", resn, 1);
    end
    applyStimulus(0, 1, 0, 0, 0);
    holdInputs(8);
    checkOutput("bounce_count", res_count, exp_cnt[7:0]);

    // Software reset, held high: exactly one 16-cycle reset.
    applyStimulus(0, 1, 1, 0, 0);
    exp_cnt++;
    checkOutput("sw_resn_low", resn, 0);
    checkOutput("sw_cause", cause, 2);
    checkOutput("sw_count", res_count, exp_cnt[7:0]);
    holdInputs(15);
    checkOutput("sw_resn_e16", resn, 0);
    holdInputs(1);
    checkOutput("sw_resn_e17", resn, 1);
    holdInputs(20);
    checkOutput("sw_held_resn", resn, 1);
    checkOutput("sw_held_count", res_count, exp_cnt[7:0]);
    applyStimulus(0, 1, 0, 0, 0);
    applyStimulus(0, 1, 1, 0, 0);
    exp_cnt++;
    checkOutput("sw2_count", res_count, exp_cnt[7:0]);
    checkOutput("sw2_cause", cause, 2);
    holdInputs(17);
    applyStimulus(0, 1, 0, 0, 0);
    holdInputs(1);

    // Watchdog enabled with no kick.
    applyStimulus(0, 1, 0, 1, 0);
    holdInputs(30);
    checkOutput("wdt_resn_e31", resn, 1);
    holdInputs(1);
`ifdef P1V_RESGEN_WDT_EN
    exp_cnt++;
    checkOutput("wdt_resn_e32", resn, 0);
    checkOutput("wdt_cause", cause, 3);
`else
    checkOutput("wdt_resn_e32", resn, 1);
    checkOutput("wdt_cause", cause, 2);
`endif
    checkOutput("wdt_count", res_count, exp_cnt[7:0]);
    applyStimulus(0, 1, 0, 0, 0);
    holdInputs(17);
    checkOutput("wdt_recover", resn, 1);
    for (int i = 0; i < 100; i++) begin
      applyStimulus(0, 1, 0, 1, (i % 20) == 19);
    end
    checkOutput("wdt_kick_resn", resn, 1);
    checkOutput("wdt_kick_count", res_count, exp_cnt[7:0]);
    applyStimulus(0, 1, 0, 0, 0);

    // Button and software edge reach the FSM on the same edge: button wins.
    applyStimulus(0, 0, 0, 0, 0);
    holdInputs(5);
    applyStimulus(0, 0, 1, 0, 0);
    exp_cnt++;
    checkOutput("sim_resn", resn, 0);
    checkOutput("sim_cause", cause, 1);
    checkOutput("sim_count", res_count, exp_cnt[7:0]);
    applyStimulus(0, 1, 1, 0, 0);
    holdInputs(25);
    checkOutput("sim_done_resn", resn, 1);
    checkOutput("sim_done_count", res_count, exp_cnt[7:0]);
    applyStimulus(0, 1, 0, 0, 0);

    // res asserted mid-hold restarts the full power-on sequence.
    applyStimulus(0, 1, 1, 0, 0);
    holdInputs(5);
    applyStimulus(1, 1, 1, 0, 0);
    checkOutput("abort_resn", resn, 0);
    checkOutput("abort_count", res_count, 0);
    checkOutput("abort_cause", cause, 0);
    checkOutput("abort_busy", busy, 1);
    applyStimulus(0, 1, 1, 0, 0);
    holdInputs(14);
    checkOutput("abort_e15", resn, 0);
    holdInputs(1);
    checkOutput("abort_e16", resn, 1);
    applyStimulus(0, 1, 0, 0, 0);

    // Randomized traffic; the negedge model check covers every cycle.
    b        = 1'b1;
    btn_left = 0;
    for (int i = 0; i < 2500; i++) begin
      if (btn_left == 0) begin
        b        = ($urandom_range(0, 2) != 0);
        btn_left = $urandom_range(1, 10);
      end
      btn_left--;
      applyStimulus($urandom_range(0, 399) == 0, b,
                    ($urandom_range(0, 19) == 0) ? ~sw_res : sw_res,
                    ($urandom_range(0, 49) == 0) ? ~wdt_en : wdt_en,
                    $urandom_range(0, 24) == 0);
    end

    chk_on = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
